fp_round_pipe: RTL and testbench
================================

FP_ROUND_PIPE -- requirements
Module: fp_round_pipe

Interface
REQ-001 SHALL have parameter exp_width, default 8, exponent field width.
REQ-002 SHALL have parameter frac_width, default 23, stored fraction width (no hidden bit).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input operand present.
REQ-006 SHALL have port in_ready  output  1  block accepts operand this cycle.
REQ-007 SHALL have port in_sign  input  1  operand sign.
REQ-008 SHALL have port in_exp  input  exp_width  biased exponent before rounding.
REQ-009 SHALL have port in_frac  input  frac_width+3  fraction without hidden bit; bits [2:0] = guard, round, sticky.
REQ-010 SHALL have port in_mode  input  3  0 nearest-even, 1 toward-zero, 2 downward, 3 upward, 4 nearest-away; 5-7 treated as 0.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have ports out_sign / out_exp / out_frac  output  1 / exp_width / frac_width  rounded result.
REQ-014 SHALL have ports out_inexact / out_overflow  output  1 / 1  per-result exception flags.
REQ-015 SHALL have port clear_flags  input  1  clears accrued flags.
REQ-016 SHALL have ports acc_inexact / acc_overflow  output  1 / 1  sticky accrued flags.

Function
REQ-017 SHALL be a 2-stage pipeline: S1 registers operand plus round_up decision; S2 registers rounded result and flags; latency exactly 2 cycles from input transfer to out_valid with out_ready held high.
REQ-018 SHALL transfer input when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready (S1 advances iff S2 empty or draining); full throughput of 1 result/cycle under continuous out_ready.
REQ-020 SHALL hold out_* and out_valid stable while out_valid && !out_ready; no operand lost or duplicated under any backpressure pattern.
REQ-021 SHALL compute round_up: mode 0 = G&(L|R|S), L = in_frac[3]; mode 1 = 0; mode 2 = sign&(G|R|S); mode 3 = !sign&(G|R|S); mode 4 = G.
REQ-022 SHALL add round_up to {1, in_frac[frac_width+2:3]} (frac_width+2 bits); on carry out, out_frac = sum shifted right by 1, bits [frac_width:1], and exponent incremented by 1.
REQ-023 SHALL set out_inexact = G|R|S for finite operands.
REQ-024 SHALL set out_overflow and out_inexact when post-rounding exponent reaches all-ones; result is +/-infinity (exp all-ones, frac 0) for modes 0, 4, mode 3 with sign 0, mode 2 with sign 1; otherwise max finite (exp all-ones minus 1, frac all-ones).
REQ-025 SHALL pass operands with in_exp all-ones (inf/NaN) unchanged: out_frac = in_frac[frac_width+2:3], no rounding, both flags 0.
REQ-026 SHALL pass out_sign = in_sign unchanged in all cases.
REQ-027 SHALL OR out_inexact/out_overflow into acc_inexact/acc_overflow on each output transfer only.
REQ-028 SHALL clear accrued flags on clear_flags; if clear and a flag-setting output transfer occur in the same cycle, accrued flags equal that transfer's flags.

Reset
REQ-029 SHALL on reset clear s1_valid, s2_valid, out_valid, acc_inexact, acc_overflow; in_ready = 1 in the cycle after reset deasserts.
REQ-030 SHALL discard in-flight operands when reset asserts mid-operation; no out_valid for them afterwards.
REQ-031 SHALL leave datapath registers unreset; out_sign/out_exp/out_frac/out_inexact/out_overflow don't-care while out_valid = 0.

Verification
REQ-032 SHALL verify: defaults, mode 0, exp 0x7F, frac 0x000001_4 (L=1,G=1) -> exp 0x7F, frac 0x000002, inexact 1, out_valid exactly 2 cycles after transfer.
REQ-033 SHALL verify: mode 0, exp 0xFE, frac all-ones, GRS=100 -> overflow 1, inexact 1, exp 0xFF, frac 0; same with mode 1 -> exp 0xFE, frac 0x7FFFFF, overflow 0, inexact 1.
REQ-034 SHALL verify: mode 4 vs mode 0, frac 0x000000_4 (L=0, G=1) -> mode 4 frac 0x000001, mode 0 frac 0x000000; both inexact 1.
REQ-035 SHALL verify: 100 back-to-back operands with random out_ready -> all results in order, none dropped, outputs stable while stalled.
REQ-036 SHALL verify: in_exp 0xFF, frac nonzero -> payload unchanged, flags 0, accrued flags unchanged.
REQ-037 SHALL verify: reset asserted with two operands in flight -> no out_valid for them afterwards, acc_inexact 0; clear_flags coinciding with inexact transfer -> acc_inexact 1.

Source files
------------

// File: rtl/fp_round_pipe.sv
// Two-stage floating-point rounding pipeline with valid/ready handshake.
// Stage 1 captures the operand and the round-up decision. Stage 2 applies the
// increment, renormalises, detects overflow and registers the result and flags.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready               operand handshake
//   in_sign/in_exp/in_frac/in_mode  operand (in_frac[2:0] = guard/round/sticky), rounding mode
//   out_valid/out_ready             result handshake
//   out_sign/out_exp/out_frac       rounded result
//   out_inexact/out_overflow        per-result exception flags
//   clear_flags                     clears the accrued flags
//   acc_inexact/acc_overflow        sticky accrued flags
module fp_round_pipe #(
    parameter int unsigned exp_width  = 8,
    parameter int unsigned frac_width = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [exp_width-1:0]  in_exp,
    input  logic [frac_width+2:0] in_frac,
    input  logic [2:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [exp_width-1:0]  out_exp,
    output logic [frac_width-1:0] out_frac,
    output logic                  out_inexact,
    output logic                  out_overflow,
    input  logic                  clear_flags,
    output logic                  acc_inexact,
    output logic                  acc_overflow
);

    localparam int unsigned SUM_W = frac_width + 2;
    localparam int unsigned EXP_W1 = exp_width + 1;

    localparam logic [2:0] MODE_RNE = 3'd0;
    localparam logic [2:0] MODE_RTZ = 3'd1;
    localparam logic [2:0] MODE_RDN = 3'd2;
    localparam logic [2:0] MODE_RUP = 3'd3;
    localparam logic [2:0] MODE_RMM = 3'd4;

    localparam logic [exp_width-1:0]  EXP_ONES = {exp_width{1'b1}};
    localparam logic [exp_width-1:0]  EXP_MAXF = {{(exp_width-1){1'b1}}, 1'b0};
    localparam logic [frac_width-1:0] FRAC_ONES = {frac_width{1'b1}};

    // Stage 1 registers
    logic                  s1_valid;
    logic                  s1_sign;
    logic [exp_width-1:0]  s1_exp;
    logic [frac_width-1:0] s1_frac;
    logic                  s1_round_up;
    logic                  s1_inexact;
    logic                  s1_special;
    logic                  s1_inf_ok;

    logic                  s2_valid;

    // Handshake
    logic s2_en;
    logic in_fire;
    logic s1_move;
    logic out_fire;

    assign s2_en     = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign s1_move   = s1_valid && s2_en;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // Stage 1 decision: round-up bit, inexact, and overflow target (inf vs max finite)
    logic [2:0] mode_c;
    logic       guard_c, round_c, sticky_c, lsb_c, grs_any_c;
    logic       round_up_c, inf_ok_c, special_c;

    always_comb begin
        mode_c     = (in_mode > MODE_RMM) ? MODE_RNE : in_mode;
        guard_c    = in_frac[2];
        round_c    = in_frac[1];
        sticky_c   = in_frac[0];
        lsb_c      = in_frac[3];
        grs_any_c  = guard_c || round_c || sticky_c;
        special_c  = (in_exp == EXP_ONES);
        round_up_c = 1'b0;
        inf_ok_c   = 1'b0;
        case (mode_c)
            MODE_RNE: begin
                round_up_c = guard_c && (lsb_c || round_c || sticky_c);
                inf_ok_c   = 1'b1;
            end
            MODE_RTZ: begin
                round_up_c = 1'b0;
                inf_ok_c   = 1'b0;
            end
            MODE_RDN: begin
                round_up_c = in_sign && grs_any_c;
                inf_ok_c   = in_sign;
            end
            MODE_RUP: begin
                round_up_c = !in_sign && grs_any_c;
                inf_ok_c   = !in_sign;
            end
            default: begin
                round_up_c = guard_c;
                inf_ok_c   = 1'b1;
            end
        endcase
    end

    // Stage 2 arithmetic: increment the significand with hidden bit, renormalise on carry
    logic [SUM_W-1:0]      sum_c;
    logic                  carry_c;
    logic [EXP_W1-1:0]     exp_inc_c;
    logic [exp_width-1:0]  res_exp_c;
    logic [frac_width-1:0] res_frac_c;
    logic                  res_inexact_c;
    logic                  res_overflow_c;

    always_comb begin
        sum_c          = {1'b0, 1'b1, s1_frac} + SUM_W'(s1_round_up);
        carry_c        = sum_c[SUM_W-1];
        exp_inc_c      = {1'b0, s1_exp} + EXP_W1'(carry_c);
        res_exp_c      = exp_inc_c[exp_width-1:0];
        res_frac_c     = carry_c ? sum_c[frac_width:1] : sum_c[frac_width-1:0];
        res_inexact_c  = s1_inexact;
        res_overflow_c = 1'b0;
        if (s1_special) begin
            // inf/NaN pass through untouched
            res_exp_c     = s1_exp;
            res_frac_c    = s1_frac;
            res_inexact_c = 1'b0;
        end else if (exp_inc_c >= {1'b0, EXP_ONES}) begin
            res_overflow_c = 1'b1;
            res_inexact_c  = 1'b1;
            if (s1_inf_ok) begin
                res_exp_c  = EXP_ONES;
                res_frac_c = '0;
            end else begin
                res_exp_c  = EXP_MAXF;
                res_frac_c = FRAC_ONES;
            end
        end
    end

    // Control state and accrued flags
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            acc_inexact  <= 1'b0;
            acc_overflow <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
            end
            // A clear coinciding with a transfer leaves exactly that transfer's flags
            if (clear_flags) begin
                acc_inexact  <= out_fire && out_inexact;
                acc_overflow <= out_fire && out_overflow;
            end else if (out_fire) begin
                acc_inexact  <= acc_inexact || out_inexact;
                acc_overflow <= acc_overflow || out_overflow;
            end
        end
    end

    // Datapath registers, intentionally unreset
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_sign     <= in_sign;
            s1_exp      <= in_exp;
            s1_frac     <= in_frac[frac_width+2:3];
            s1_round_up <= round_up_c && !special_c;
            s1_inexact  <= grs_any_c && !special_c;
            s1_special  <= special_c;
            s1_inf_ok   <= inf_ok_c;
        end
        if (s1_move) begin
            out_sign     <= s1_sign;
            out_exp      <= res_exp_c;
            out_frac     <= res_frac_c;
            out_inexact  <= res_inexact_c;
            out_overflow <= res_overflow_c;
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Self-checking bench for fp_round_pipe: directed corner cases plus randomized
// operands with random backpressure, checked against an integer reference model.
module tb_fp_round_pipe;

    localparam int unsigned EW = 8;
    localparam int unsigned FW = 23;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [EW-1:0] in_exp;
    logic [FW+2:0] in_frac;
    logic [2:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [FW-1:0] out_frac;
    logic          out_inexact;
    logic          out_overflow;
    logic          clear_flags;
    logic          acc_inexact;
    logic          acc_overflow;

    fp_round_pipe #(.exp_width(EW), .frac_width(FW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
        .out_inexact(out_inexact), .out_overflow(out_overflow),
        .clear_flags(clear_flags),
        .acc_inexact(acc_inexact), .acc_overflow(acc_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: {sign, exp, frac, inexact, overflow}
    function automatic logic [33:0] ref_round(input logic s, input logic [7:0] e,
                                              input logic [25:0] f, input logic [2:0] m);
        int unsigned mant, ex, mode;
        logic g, r, st, up, inx, ovf, to_inf;
        logic [22:0] fr;
        if (e == 8'hFF) return {s, e, f[25:3], 2'b00};
        mode = (m > 3'd4) ? 0 : int'(m);
        g = f[2]; r = f[1]; st = f[0];
        case (mode)
            0: up = g && (f[3] || r || st);
            1: up = 1'b0;
            2: up = s && (g || r || st);
            3: up = !s && (g || r || st);
            default: up = g;
        endcase
        mant = (32'd1 << 23) + int'(f[25:3]) + int'(up);
        ex = int'(e);
        if (mant >= (32'd1 << 24)) begin
            mant = mant / 2;
            ex = ex + 1;
        end
        inx = g || r || st;
        ovf = 1'b0;
        fr = 23'(mant % (32'd1 << 23));
        if (ex >= 255) begin
            ovf = 1'b1;
            inx = 1'b1;
            to_inf = (mode == 0) || (mode == 4) || (mode == 3 && !s) || (mode == 2 && s);
            if (to_inf) begin
                ex = 255;
                fr = '0;
            end else begin
                ex = 254;
                fr = '1;
            end
        end
        return {s, 8'(ex), fr, inx, ovf};
    endfunction

    logic [33:0] payload;
    assign payload = {out_sign, out_exp, out_frac, out_inexact, out_overflow};

    logic [33:0] exp_q[$];
    logic        acc_i_m = 1'b0;
    logic        acc_o_m = 1'b0;
    logic        stall_prev = 1'b0;
    logic [33:0] prev_payload;

    // Scoreboard and accrued-flag model, sampled mid-cycle
    always @(negedge clk) begin
        logic [33:0] e;
        logic        fire;
        if (reset) begin
            exp_q.delete();
            acc_i_m    = 1'b0;
            acc_o_m    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("acc_inexact", 64'(acc_inexact), 64'(acc_i_m));
            check("acc_overflow", 64'(acc_overflow), 64'(acc_o_m));
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'(payload), 64'(prev_payload));
            end
            e    = '0;
            fire = out_valid && out_ready;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(payload), 64'(e));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_round(in_sign, in_exp, in_frac, in_mode));
            if (clear_flags) begin
                acc_i_m = fire && e[1];
                acc_o_m = fire && e[0];
            end else if (fire) begin
                acc_i_m = acc_i_m || e[1];
                acc_o_m = acc_o_m || e[0];
            end
            stall_prev   = out_valid && !out_ready;
            prev_payload = payload;
        end
    end

    // Present one operand and hold it until it is accepted
    task automatic send(input logic s, input logic [7:0] e, input logic [25:0] f, input logic [2:0] m);
        bit done = 0;
        int n = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_frac  = f;
        in_mode  = m;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                check("send_timeout", 64'(in_ready), 64'd1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_out", 64'(out_valid), 64'd1);
    endtask

    bit rnd_run = 0;

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_frac = '0;
        in_mode = '0; out_ready = 1'b1; clear_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_acc_inexact", 64'(acc_inexact), 64'd0);
        check("rst_acc_overflow", 64'(acc_overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Nearest-even rounds up on L=1,G=1 with exactly two cycles of latency
        send(1'b0, 8'h7F, {23'h000001, 3'b100}, 3'd0);
        check("lat_c1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_c2_valid", 64'(out_valid), 64'd1);
        check("rne_exp", 64'(out_exp), 64'h7F);
        check("rne_frac", 64'(out_frac), 64'h000002);
        check("rne_inexact", 64'(out_inexact), 64'd1);
        @(posedge clk);
        #1;

        // Overflow to infinity vs clamp to max finite
        send(1'b0, 8'hFE, {23'h7FFFFF, 3'b100}, 3'd0);
        wait_out();
        check("ovf_rne_exp", 64'(out_exp), 64'hFF);
        check("ovf_rne_frac", 64'(out_frac), 64'h0);
        check("ovf_rne_flag", 64'(out_overflow), 64'd1);
        check("ovf_rne_inexact", 64'(out_inexact), 64'd1);
        @(posedge clk);
        #1;
        send(1'b0, 8'hFE, {23'h7FFFFF, 3'b100}, 3'd1);
        wait_out();
        check("ovf_rtz_exp", 64'(out_exp), 64'hFE);
        check("ovf_rtz_frac", 64'(out_frac), 64'h7FFFFF);
        check("ovf_rtz_flag", 64'(out_overflow), 64'd0);
        check("ovf_rtz_inexact", 64'(out_inexact), 64'd1);
        @(posedge clk);
        #1;

        // Ties: away-from-zero vs nearest-even with L=0
        send(1'b0, 8'h40, {23'h000000, 3'b100}, 3'd4);
        wait_out();
        check("rmm_frac", 64'(out_frac), 64'h000001);
        check("rmm_inexact", 64'(out_inexact), 64'd1);
        @(posedge clk);
        #1;
        send(1'b0, 8'h40, {23'h000000, 3'b100}, 3'd0);
        wait_out();
        check("tie_rne_frac", 64'(out_frac), 64'h000000);
        check("tie_rne_inexact", 64'(out_inexact), 64'd1);
        @(posedge clk);
        #1;

        // Clear flags with nothing transferring, then pass a NaN through
        clear_flags = 1'b1;
        @(posedge clk);
        #1;
        clear_flags = 1'b0;
        send(1'b1, 8'hFF, {23'h400123, 3'b111}, 3'd3);
        wait_out();
        check("nan_exp", 64'(out_exp), 64'hFF);
        check("nan_frac", 64'(out_frac), 64'h400123);
        check("nan_sign", 64'(out_sign), 64'd1);
        check("nan_inexact", 64'(out_inexact), 64'd0);
        check("nan_overflow", 64'(out_overflow), 64'd0);
        @(posedge clk);
        #1;
        check("nan_acc_inexact", 64'(acc_inexact), 64'd0);
        check("nan_acc_overflow", 64'(acc_overflow), 64'd0);

        // Clear coinciding with an inexact transfer keeps that transfer's flag
        out_ready = 1'b0;
        send(1'b0, 8'h10, {23'h000003, 3'b001}, 3'd1);
        wait_out();
        clear_flags = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        clear_flags = 1'b0;
        check("clr_coincide_acc", 64'(acc_inexact), 64'd1);

        // Reset with two operands in flight discards them
        out_ready = 1'b0;
        send(1'b0, 8'h20, {23'h000010, 3'b011}, 3'd0);
        send(1'b1, 8'h21, {23'h000020, 3'b101}, 3'd2);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("flush_out_valid", 64'(out_valid), 64'd0);
        end
        check("flush_acc_inexact", 64'(acc_inexact), 64'd0);

        // Randomized operands under random backpressure
        rnd_run = 1;
        fork
            begin
                while (rnd_run) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 100; i++) begin
            logic [7:0]  e;
            logic [25:0] f;
            int          sel;
            sel = int'($urandom_range(0, 9));
            e = (sel == 0) ? 8'hFE : (sel == 1) ? 8'hFF : 8'($urandom);
            f = 26'($urandom);
            if ($urandom_range(0, 3) == 0) f[25:3] = '1;
            if (i == 40) clear_flags = 1'b1;
            if (i == 41) clear_flags = 1'b0;
            send(1'($urandom), e, f, 3'($urandom_range(0, 7)));
        end
        clear_flags = 1'b0;
        rnd_run = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 500) begin
                @(posedge clk);
                n++;
            end
            #1;
            check("drain_empty", 64'(exp_q.size()), 64'd0);
        end
        @(posedge clk);
        #1;
        check("idle_out_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
